// File: rtl/hdmi_stream_frame_ctrl.sv
// hdmi_stream_frame_ctrl
// Locks an AXI-stream pixel source to the raster of a video timing generator.
// The stream start-of-frame is aligned to frame_start, and each data_req is
// answered with one registered pixel. Line and frame framing is checked on the
// way through. On underflow or loss of sync the block outputs a background
// colour and then finds the next start-of-frame on its own.

module hdmi_stream_frame_ctrl #(
  parameter int          H_ACTIVE = 1280,
  parameter int          V_ACTIVE = 720,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic        pixel_clk,
  input  logic        sys_rst,
  input  logic        enable,
  input  logic [23:0] s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tuser,
  input  logic        s_tlast,
  output logic        s_tready,
  input  logic        frame_start,
  input  logic        data_req,
  output logic [23:0] pixel_data,
  output logic        locked,
  output logic        underflow,
  output logic        sync_err,
  output logic [7:0]  err_cnt
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEEK_SOF,
    WAIT_FRAME,
    ACTIVE
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [23:0]     pix_q, pix_d;
  logic            locked_q, locked_d;
  logic            under_q, under_d;
  logic            sync_q, sync_d;
  logic            frameErr_q, frameErr_d;
  logic [7:0]      cnt_q, cnt_d;

  logic atOrigin;
  logic lastX;
  logic lastY;
  logic sofBeat;
  logic midSof;

  assign atOrigin = (x_q == '0) && (y_q == '0);
  assign lastX    = (x_q == XW'(H_ACTIVE - 1));
  assign lastY    = (y_q == YW'(V_ACTIVE - 1));
  assign sofBeat  = s_tvalid & s_tuser;
  assign midSof   = sofBeat & ~atOrigin;

  // Stream ready: drop beats until SOF in SEEK_SOF. In ACTIVE, take one beat
  // per request, but hold back a stray SOF or any beat that arrives with frame_start.
  always_comb begin
    s_tready = 1'b0;
    if (enable) begin
      case (state_q)
        SEEK_SOF: s_tready = ~sofBeat;
        ACTIVE:   s_tready = data_req & ~frame_start & ~midSof;
        default:  s_tready = 1'b0;
      endcase
    end
  end

  // Next-state logic: raster position, pixel selection, framing checks and
  // error bookkeeping.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    pix_d      = pix_q;
    locked_d   = locked_q;
    under_d    = 1'b0;
    sync_d     = 1'b0;
    frameErr_d = frameErr_q;
    cnt_d      = cnt_q;

    if (!enable) begin
      state_d  = IDLE;
      locked_d = 1'b0;
      if (data_req) begin
        pix_d = BG_COLOR;
      end
    end else begin
      if (data_req) begin
        pix_d = BG_COLOR;
      end
      case (state_q)
        IDLE: begin
          state_d = SEEK_SOF;
        end
        SEEK_SOF: begin
          if (sofBeat) begin
            state_d = WAIT_FRAME;
          end
        end
        WAIT_FRAME: begin
          if (frame_start) begin
            x_d        = '0;
            y_d        = '0;
            frameErr_d = 1'b0;
            state_d    = ACTIVE;
          end
        end
        ACTIVE: begin
          if (frame_start) begin
            sync_d  = 1'b1;
            state_d = SEEK_SOF;
          end else if (data_req) begin
            if (midSof) begin
              sync_d  = 1'b1;
              state_d = WAIT_FRAME;
            end else begin
              if (s_tvalid) begin
                pix_d = s_tdata;
                if (s_tlast != lastX) begin
                  sync_d  = 1'b1;
                  state_d = SEEK_SOF;
                end
              end else begin
                under_d = 1'b1;
              end
              if (lastX) begin
                x_d = '0;
                y_d = lastY ? '0 : y_q + 1'b1;
              end else begin
                x_d = x_q + 1'b1;
              end
              if (lastX && lastY) begin
                state_d  = SEEK_SOF;
                locked_d = ~frameErr_q;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (under_d || sync_d) begin
      locked_d   = 1'b0;
      frameErr_d = 1'b1;
      if (cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      pix_q      <= BG_COLOR;
      locked_q   <= 1'b0;
      under_q    <= 1'b0;
      sync_q     <= 1'b0;
      frameErr_q <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      pix_q      <= pix_d;
      locked_q   <= locked_d;
      under_q    <= under_d;
      sync_q     <= sync_d;
      frameErr_q <= frameErr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pixel_data = pix_q;
  assign locked     = locked_q;
  assign underflow  = under_q;
  assign sync_err   = sync_q;
  assign err_cnt    = cnt_q;

endmodule

// File: tb/tb_hdmi_stream_frame_ctrl.sv
// Directed testbench for hdmi_stream_frame_ctrl with a 4x2 raster.
// Inputs change 1 ns after the rising edge. Registered outputs are checked
// after that same edge, and combinational s_tready is checked before the next edge.

module tb_hdmi_stream_frame_ctrl;

  localparam int          HA = 4;
  localparam int          VA = 2;
  localparam logic [23:0] BG = 24'h000000;

  logic        pixel_clk = 1'b0;
  logic        sys_rst;
  logic        enable;
  logic [23:0] s_tdata;
  logic        s_tvalid;
  logic        s_tuser;
  logic        s_tlast;
  logic        s_tready;
  logic        frame_start;
  logic        data_req;
  logic [23:0] pixel_data;
  logic        locked;
  logic        underflow;
  logic        sync_err;
  logic [7:0]  err_cnt;

  int passCnt  = 0;
  int checkCnt = 0;

  hdmi_stream_frame_ctrl #(
    .H_ACTIVE (HA),
    .V_ACTIVE (VA),
    .BG_COLOR (BG)
  ) dut (
    .pixel_clk   (pixel_clk),
    .sys_rst     (sys_rst),
    .enable      (enable),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tuser     (s_tuser),
    .s_tlast     (s_tlast),
    .s_tready    (s_tready),
    .frame_start (frame_start),
    .data_req    (data_req),
    .pixel_data  (pixel_data),
    .locked      (locked),
    .underflow   (underflow),
    .sync_err    (sync_err),
    .err_cnt     (err_cnt)
  );

  // 100 MHz pixel clock.
  always #5 pixel_clk = ~pixel_clk;

  // Stops a hung run and still reports it.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic setBeat(input logic v, input logic [23:0] d, input logic u, input logic l);
    s_tvalid = v;
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
  endtask

  task automatic doReset();
    sys_rst     = 1'b1;
    enable      = 1'b0;
    frame_start = 1'b0;
    data_req    = 1'b0;
    setBeat(1'b0, 24'h0, 1'b0, 1'b0);
    tick();
    sys_rst = 1'b0;
  endtask

  // Leave IDLE so the block is searching for a start-of-frame.
  task automatic enableSeek();
    enable = 1'b1;
    tick();
  endtask

  // From SEEK_SOF, present the SOF beat and then frame_start. The SOF beat
  // stays on the bus for the first request.
  task automatic startFrame(input logic [23:0] firstPix);
    data_req = 1'b0;
    setBeat(1'b1, firstPix, 1'b1, 1'b0);
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    enable   = 1'b1;
    s_tvalid = 1'b1;
    data_req = 1'b1;
    sys_rst  = 1'b1;
    #3;
    checkCnt++; if (pixel_data !== BG) $display("[TB] FAIL rst_pix got %h expected %h", pixel_data, BG); else passCnt++;
    checkCnt++; if (locked !== 1'b0) $display("[TB] FAIL rst_locked got %b expected 0", locked); else passCnt++;
    checkCnt++; if (underflow !== 1'b0) $display("[TB] FAIL rst_underflow got %b expected 0", underflow); else passCnt++;
    checkCnt++; if (sync_err !== 1'b0) $display("[TB] FAIL rst_sync_err got %b expected 0", sync_err); else passCnt++;
    checkCnt++; if (err_cnt !== 8'd0) $display("[TB] FAIL rst_err_cnt got %0d expected 0", err_cnt); else passCnt++;
    checkCnt++; if (s_tready !== 1'b0) $display("[TB] FAIL rst_tready got %b expected 0", s_tready); else passCnt++;
  endtask

  task automatic test_garbage();
    doReset();
    enableSeek();
    for (int i = 0; i < 3; i++) begin
      setBeat(1'b1, 24'hAAAAAA, 1'b0, 1'b0);
      #1;
      checkCnt++; if (s_tready !== 1'b1) $display("[TB] FAIL garbage_drop%0d got tready %b expected 1", i, s_tready); else passCnt++;
      tick();
    end
    startFrame(24'h000001);
    for (int i = 0; i < 8; i++) begin
      setBeat(1'b1, 24'(i + 1), (i == 0), ((i % 4) == 3));
      data_req = 1'b1;
      tick();
      checkCnt++; if (pixel_data !== 24'(i + 1)) $display("[TB] FAIL garbage_pix%0d got %h expected %h", i, pixel_data, 24'(i + 1)); else passCnt++;
    end
    data_req = 1'b0;
    setBeat(1'b0, 24'h0, 1'b0, 1'b0);
    checkCnt++; if (err_cnt !== 8'd0) $display("[TB] FAIL garbage_err_cnt got %0d expected 0", err_cnt); else passCnt++;
  endtask

  task automatic test_nominal();
    doReset();
    enableSeek();
    setBeat(1'b1, 24'h000001, 1'b1, 1'b0);
    #1;
    checkCnt++; if (s_tready !== 1'b0) $display("[TB] FAIL nom_sof_held got tready %b expected 0", s_tready); else passCnt++;
    startFrame(24'h000001);
    for (int i = 0; i < 8; i++) begin
      setBeat(1'b1, 24'(i + 1), (i == 0), ((i % 4) == 3));
      data_req = 1'b1;
      #1;
      checkCnt++; if (s_tready !== 1'b1) $display("[TB] FAIL nom_ready%0d got %b expected 1", i, s_tready); else passCnt++;
      tick();
      checkCnt++; if (pixel_data !== 24'(i + 1)) $display("[TB] FAIL nom_pix%0d got %h expected %h", i, pixel_data, 24'(i + 1)); else passCnt++;
      if (i == 6) begin
        checkCnt++; if (locked !== 1'b0) $display("[TB] FAIL nom_locked_early got %b expected 0", locked); else passCnt++;
      end
    end
    data_req = 1'b0;
    setBeat(1'b0, 24'h0, 1'b0, 1'b0);
    checkCnt++; if (locked !== 1'b1) $display("[TB] FAIL nom_locked got %b expected 1", locked); else passCnt++;
    checkCnt++; if (err_cnt !== 8'd0) $display("[TB] FAIL nom_err_cnt got %0d expected 0", err_cnt); else passCnt++;
    tick();
    checkCnt++; if (pixel_data !== 24'h000008) $display("[TB] FAIL nom_hold got %h expected 000008", pixel_data); else passCnt++;
  endtask

  // Runs straight after test_nominal: locked is high and the block is in SEEK_SOF.
  task automatic test_underflow();
    startFrame(24'h000001);
    data_req = 1'b1;
    setBeat(1'b1, 24'h000001, 1'b1, 1'b0);
    tick();
    setBeat(1'b1, 24'h000002, 1'b0, 1'b0);
    tick();
    checkCnt++; if (pixel_data !== 24'h000002) $display("[TB] FAIL uf_pix2 got %h expected 000002", pixel_data); else passCnt++;
    setBeat(1'b0, 24'h0, 1'b0, 1'b0);
    tick();
    checkCnt++; if (pixel_data !== BG) $display("[TB] FAIL uf_pix_bg got %h expected %h", pixel_data, BG); else passCnt++;
    checkCnt++; if (underflow !== 1'b1) $display("[TB] FAIL uf_pulse got %b expected 1", underflow); else passCnt++;
    checkCnt++; if (err_cnt !== 8'd1) $display("[TB] FAIL uf_err_cnt got %0d expected 1", err_cnt); else passCnt++;
    checkCnt++; if (locked !== 1'b0) $display("[TB] FAIL uf_locked got %b expected 0", locked); else passCnt++;
    setBeat(1'b1, 24'h000003, 1'b0, 1'b0);
    tick();
    checkCnt++; if (sync_err !== 1'b1) $display("[TB] FAIL uf_tlast_sync got %b expected 1", sync_err); else passCnt++;
    checkCnt++; if (underflow !== 1'b0) $display("[TB] FAIL uf_pulse_end got %b expected 0", underflow); else passCnt++;
    checkCnt++; if (pixel_data !== 24'h000003) $display("[TB] FAIL uf_tlast_pix got %h expected 000003", pixel_data); else passCnt++;
    checkCnt++; if (err_cnt !== 8'd2) $display("[TB] FAIL uf_err_cnt2 got %0d expected 2", err_cnt); else passCnt++;
    data_req = 1'b0;
    setBeat(1'b1, 24'h000004, 1'b0, 1'b0);
    #1;
    checkCnt++; if (s_tready !== 1'b1) $display("[TB] FAIL uf_seek_state got tready %b expected 1", s_tready); else passCnt++;
    tick();
    checkCnt++; if (sync_err !== 1'b0) $display("[TB] FAIL uf_sync_end got %b expected 0", sync_err); else passCnt++;
    setBeat(1'b0, 24'h0, 1'b0, 1'b0);
  endtask

  task automatic test_mid_sof();
    doReset();
    enableSeek();
    startFrame(24'h000010);
    data_req = 1'b1;
    setBeat(1'b1, 24'h000010, 1'b1, 1'b0);
    tick();
    setBeat(1'b1, 24'h000011, 1'b0, 1'b0);
    tick();
    checkCnt++; if (pixel_data !== 24'h000011) $display("[TB] FAIL msof_pix2 got %h expected 000011", pixel_data); else passCnt++;
    setBeat(1'b1, 24'h000020, 1'b1, 1'b0);
    #1;
    checkCnt++; if (s_tready !== 1'b0) $display("[TB] FAIL msof_refuse got tready %b expected 0", s_tready); else passCnt++;
    tick();
    checkCnt++; if (sync_err !== 1'b1) $display("[TB] FAIL msof_sync got %b expected 1", sync_err); else passCnt++;
    checkCnt++; if (pixel_data !== BG) $display("[TB] FAIL msof_bg got %h expected %h", pixel_data, BG); else passCnt++;
    #1;
    checkCnt++; if (s_tready !== 1'b0) $display("[TB] FAIL msof_held got tready %b expected 0", s_tready); else passCnt++;
    tick();
    checkCnt++; if (pixel_data !== BG) $display("[TB] FAIL msof_bg2 got %h expected %h", pixel_data, BG); else passCnt++;
    data_req    = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    data_req    = 1'b1;
    #1;
    checkCnt++; if (s_tready !== 1'b1) $display("[TB] FAIL msof_accept got tready %b expected 1", s_tready); else passCnt++;
    tick();
    checkCnt++; if (pixel_data !== 24'h000020) $display("[TB] FAIL msof_first_pix got %h expected 000020", pixel_data); else passCnt++;
    checkCnt++; if (err_cnt !== 8'd1) $display("[TB] FAIL msof_err_cnt got %0d expected 1", err_cnt); else passCnt++;
    data_req = 1'b0;
    setBeat(1'b0, 24'h0, 1'b0, 1'b0);
  endtask

  task automatic test_early_frame_start();
    doReset();
    enableSeek();
    startFrame(24'h000031);
    data_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      setBeat(1'b1, 24'(32'h31 + i), (i == 0), (i == 3));
      tick();
    end
    checkCnt++; if (pixel_data !== 24'h000035) $display("[TB] FAIL efs_pix5 got %h expected 000035", pixel_data); else passCnt++;
    setBeat(1'b1, 24'h000036, 1'b0, 1'b0);
    frame_start = 1'b1;
    #1;
    checkCnt++; if (s_tready !== 1'b0) $display("[TB] FAIL efs_tready got %b expected 0", s_tready); else passCnt++;
    tick();
    frame_start = 1'b0;
    checkCnt++; if (sync_err !== 1'b1) $display("[TB] FAIL efs_sync got %b expected 1", sync_err); else passCnt++;
    checkCnt++; if (pixel_data !== BG) $display("[TB] FAIL efs_bg got %h expected %h", pixel_data, BG); else passCnt++;
    checkCnt++; if (err_cnt !== 8'd1) $display("[TB] FAIL efs_err_cnt got %0d expected 1", err_cnt); else passCnt++;
    data_req = 1'b0;
    #1;
    checkCnt++; if (s_tready !== 1'b1) $display("[TB] FAIL efs_seek_state got tready %b expected 1", s_tready); else passCnt++;
    setBeat(1'b0, 24'h0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid_active();
    doReset();
    enableSeek();
    startFrame(24'h000041);
    data_req = 1'b1;
    setBeat(1'b1, 24'h000041, 1'b1, 1'b0);
    tick();
    checkCnt++; if (pixel_data !== 24'h000041) $display("[TB] FAIL rma_pix got %h expected 000041", pixel_data); else passCnt++;
    setBeat(1'b1, 24'h000042, 1'b0, 1'b0);
    #1;
    checkCnt++; if (s_tready !== 1'b1) $display("[TB] FAIL rma_ready got %b expected 1", s_tready); else passCnt++;
    #1;
    sys_rst = 1'b1;
    #1;
    checkCnt++; if (pixel_data !== BG) $display("[TB] FAIL rma_pix_rst got %h expected %h", pixel_data, BG); else passCnt++;
    checkCnt++; if (s_tready !== 1'b0) $display("[TB] FAIL rma_tready_rst got %b expected 0", s_tready); else passCnt++;
    checkCnt++; if (locked !== 1'b0) $display("[TB] FAIL rma_locked_rst got %b expected 0", locked); else passCnt++;
    #1;
    sys_rst  = 1'b0;
    data_req = 1'b0;
    setBeat(1'b0, 24'h0, 1'b0, 1'b0);
  endtask

  task automatic test_enable_low();
    doReset();
    enableSeek();
    startFrame(24'h000051);
    data_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      setBeat(1'b1, 24'(32'h51 + i), (i == 0), ((i % 4) == 3));
      tick();
    end
    checkCnt++; if (locked !== 1'b1) $display("[TB] FAIL en_locked got %b expected 1", locked); else passCnt++;
    startFrame(24'h000061);
    data_req = 1'b1;
    setBeat(1'b1, 24'h000061, 1'b1, 1'b0);
    tick();
    checkCnt++; if (pixel_data !== 24'h000061) $display("[TB] FAIL en_pix got %h expected 000061", pixel_data); else passCnt++;
    enable = 1'b0;
    setBeat(1'b1, 24'h000062, 1'b0, 1'b0);
    #1;
    checkCnt++; if (s_tready !== 1'b0) $display("[TB] FAIL en_tready got %b expected 0", s_tready); else passCnt++;
    tick();
    checkCnt++; if (locked !== 1'b0) $display("[TB] FAIL en_locked_clr got %b expected 0", locked); else passCnt++;
    checkCnt++; if (pixel_data !== BG) $display("[TB] FAIL en_pix_bg got %h expected %h", pixel_data, BG); else passCnt++;
    enable = 1'b1;
    #1;
    checkCnt++; if (s_tready !== 1'b0) $display("[TB] FAIL en_idle_tready got %b expected 0", s_tready); else passCnt++;
    tick();
    data_req = 1'b0;
    setBeat(1'b0, 24'h0, 1'b0, 1'b0);
  endtask

  task automatic test_err_saturation();
    doReset();
    enableSeek();
    for (int f = 0; f < 33; f++) begin
      startFrame(24'h0);
      setBeat(1'b0, 24'h0, 1'b0, 1'b0);
      data_req = 1'b1;
      for (int r = 0; r < 8; r++) begin
        tick();
      end
      data_req = 1'b0;
      if (f == 30) begin
        checkCnt++; if (err_cnt !== 8'd248) $display("[TB] FAIL sat_count248 got %0d expected 248", err_cnt); else passCnt++;
      end
    end
    checkCnt++; if (err_cnt !== 8'd255) $display("[TB] FAIL sat_count255 got %0d expected 255", err_cnt); else passCnt++;
    checkCnt++; if (underflow !== 1'b1) $display("[TB] FAIL sat_underflow got %b expected 1", underflow); else passCnt++;
  endtask

  initial begin
    sys_rst     = 1'b0;
    enable      = 1'b0;
    frame_start = 1'b0;
    data_req    = 1'b0;
    setBeat(1'b0, 24'h0, 1'b0, 1'b0);
    #2;
    test_reset();
    test_garbage();
    test_nominal();
    test_underflow();
    test_mid_sof();
    test_early_frame_start();
    test_reset_mid_active();
    test_enable_low();
    test_err_saturation();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
